// File: rtl/pong_pkg.sv
// Constants and helpers shared by the pong blocks: screen geometry,
// quadrature state codes and the decoder's FSM/move types.
package pong_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PADDLE_H = 80;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    typedef enum logic {ST_INIT, ST_TRACK} dec_state_t;
    typedef enum logic [1:0] {MV_NONE, MV_CW, MV_CCW, MV_ILLEGAL} quad_move_t;

    // Clockwise successor in the Gray sequence 00->01->11->10->00.
    function automatic logic [1:0] qs_next_cw(input logic [1:0] qs);
        case (qs)
            QS_00:   return QS_01;
            QS_01:   return QS_11;
            QS_11:   return QS_10;
            default: return QS_00;
        endcase
    endfunction

    function automatic quad_move_t classify_move(input logic [1:0] prev, input logic [1:0] cur);
        if (cur == prev)
            return MV_NONE;
        else if (cur == qs_next_cw(prev))
            return MV_CW;
        else if (prev == qs_next_cw(cur))
            return MV_CCW;
        else
            return MV_ILLEGAL;
    endfunction

endpackage

// File: rtl/rotary_paddle_decoder_debouncer.sv
// One encoder channel: two-flop synchronizer followed by a stable-count debouncer.
// i_load bypasses the debounce and copies the synchronized pin straight into stable.
module input_debouncer
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_pin,
    input  logic i_load,
    output logic o_sync,
    output logic o_stable
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            if (i_load) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sync   = r_sync;
    assign o_stable = r_stable;

endmodule

// File: rtl/rotary_paddle_decoder.sv
// Quadrature encoder to paddle Y position: per-channel debounce, INIT/TRACK
// decoder FSM with a signed substep counter, and a saturating position register.
module rotary_paddle_decoder
    import pong_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 100000,
    parameter logic [9:0] STEP            = 10'd8,
    parameter logic [9:0] POS_MIN         = 10'd0,
    parameter logic [9:0] POS_MAX         = 10'(SCREEN_H - PADDLE_H),
    parameter logic [9:0] POS_INIT        = 10'd200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       rota,
    input  logic       rotb,
    output logic [9:0] paddle_pos,
    output logic       step_valid,
    output logic       step_dir,
    output logic       quad_error
);

    logic              w_sync_a;
    logic              w_sync_b;
    logic              w_stable_a;
    logic              w_stable_b;
    logic              w_load;
    logic [1:0]        w_cur;
    quad_move_t        w_move;
    logic signed [3:0] w_sub_ext;
    logic signed [3:0] w_sub_next;

    dec_state_t        r_state;
    logic [1:0]        r_init_cnt;
    logic [1:0]        r_prev;
    logic signed [2:0] r_substep;

    function automatic logic [9:0] sat_inc(input logic [9:0] pos);
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, STEP};
        return (sum > {1'b0, POS_MAX}) ? POS_MAX : sum[9:0];
    endfunction

    // Bit 10 of the difference is the borrow out of a subtraction below zero.
    function automatic logic [9:0] sat_dec(input logic [9:0] pos);
        logic [10:0] diff;
        diff = {1'b0, pos} - {1'b0, STEP};
        return (diff[10] || (diff[9:0] < POS_MIN)) ? POS_MIN : diff[9:0];
    endfunction

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .CLK(CLK), .RESET(RESET), .i_pin(rota), .i_load(w_load),
        .o_sync(w_sync_a), .o_stable(w_stable_a)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .CLK(CLK), .RESET(RESET), .i_pin(rotb), .i_load(w_load),
        .o_sync(w_sync_b), .o_stable(w_stable_b)
    );

    // Third INIT cycle: the synchronizers have settled, so seed stable and prev.
    assign w_load    = (r_state == ST_INIT) && (r_init_cnt == 2'd2);
    assign w_cur     = {w_stable_a, w_stable_b};
    assign w_move    = classify_move(r_prev, w_cur);
    assign w_sub_ext = {r_substep[2], r_substep};

    always_comb begin
        w_sub_next = w_sub_ext;
        case (w_move)
            MV_CW:   w_sub_next = w_sub_ext + 4'sd1;
            MV_CCW:  w_sub_next = w_sub_ext - 4'sd1;
            default: w_sub_next = w_sub_ext;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_INIT;
            r_init_cnt <= 2'd0;
            r_prev     <= QS_00;
            r_substep  <= 3'sd0;
            paddle_pos <= POS_INIT;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            quad_error <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            quad_error <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (w_load) begin
                        r_prev  <= {w_sync_a, w_sync_b};
                        r_state <= ST_TRACK;
                    end else begin
                        r_init_cnt <= r_init_cnt + 2'd1;
                    end
                end
                default: begin
                    r_prev <= w_cur;
                    if (w_move == MV_ILLEGAL) begin
                        quad_error <= 1'b1;
                        r_substep  <= 3'sd0;
                    end else if (w_sub_next == 4'sd4) begin
                        r_substep  <= 3'sd0;
                        step_valid <= 1'b1;
                        step_dir   <= 1'b1;
                        paddle_pos <= sat_inc(paddle_pos);
                    end else if (w_sub_next == -4'sd4) begin
                        r_substep  <= 3'sd0;
                        step_valid <= 1'b1;
                        step_dir   <= 1'b0;
                        paddle_pos <= sat_dec(paddle_pos);
                    end else begin
                        r_substep <= w_sub_next[2:0];
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotary_paddle_decoder.sv
// Bench for rotary_paddle_decoder: detent table plus hand-written corner sequences,
// with expected steps queued at drive time and matched when step_valid fires.
`timescale 1ns/1ps
module tb_rotary_paddle_decoder;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int LAT  = 2 + DEB + 1;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic       rota  = 1'b1;
    logic       rotb  = 1'b1;
    logic [9:0] paddle_pos;
    logic       step_valid;
    logic       step_dir;
    logic       quad_error;

    rotary_paddle_decoder #(
        .DEBOUNCE_CYCLES(DEB), .STEP(10'd8), .POS_MIN(10'd0),
        .POS_MAX(10'd400), .POS_INIT(10'd200)
    ) dut (
        .CLK(CLK), .RESET(RESET), .rota(rota), .rotb(rotb),
        .paddle_pos(paddle_pos), .step_valid(step_valid),
        .step_dir(step_dir), .quad_error(quad_error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic dir;
        int   pos;
        int   cyc;
    } exp_t;

    typedef struct {
        logic [7:0] seq;
        int         reps;
        bit         steps;
        bit         dir;
    } vec_t;

    exp_t sb[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   qerr_seen = 0;
    int   model_pos = 200;
    bit   mon_en    = 1'b0;
    bit   sv_due;
    exp_t head;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (quad_error === 1'b1) qerr_seen++;
            sv_due = (sb.size() != 0) && (sb[0].cyc == cyc);
            if (sv_due || step_valid !== 1'b0) begin
                check("step_valid", 32'(step_valid), 32'(sv_due));
                if (sv_due) begin
                    head = sb.pop_front();
                    check("step_dir", 32'(step_dir), 32'(head.dir));
                    check("step pos", 32'(paddle_pos), head.pos);
                end
            end
        end
    end

    task automatic set_pins(input logic [1:0] ab, input int hold);
        {rota, rotb} = ab;
        repeat (hold) @(posedge CLK);
        #1;
    endtask

    task automatic drive_detent(input logic [7:0] seq, input bit steps, input bit dir);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (k == 3 && steps) begin
                if (dir) model_pos = (model_pos + 8 > 400) ? 400 : model_pos + 8;
                else     model_pos = (model_pos - 8 < 0) ? 0 : model_pos - 8;
                e.dir = dir;
                e.pos = model_pos;
                e.cyc = cyc + LAT;
                sb.push_back(e);
            end
            set_pins(seq[7-2*k -: 2], HOLD);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];
    int   q0;

    initial begin
        vecs[0] = '{8'b01_11_10_00, 1,  1'b1, 1'b1};
        vecs[1] = '{8'b10_11_01_00, 2,  1'b1, 1'b0};
        vecs[2] = '{8'b10_11_01_00, 24, 1'b1, 1'b0};
        vecs[3] = '{8'b10_11_01_00, 1,  1'b1, 1'b0};
        vecs[4] = '{8'b01_11_10_00, 50, 1'b1, 1'b1};
        vecs[5] = '{8'b01_11_10_00, 1,  1'b1, 1'b1};
        vecs[6] = '{8'b01_11_01_00, 1,  1'b0, 1'b0};

        // Reset with pins resting at 11
        @(posedge CLK); #1;
        mon_en = 1'b1;
        check("reset pos", 32'(paddle_pos), 200);
        check("reset step_valid", 32'(step_valid), 0);
        check("reset quad_error", 32'(quad_error), 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        repeat (HOLD + 5) @(posedge CLK); #1;
        check("init pos", 32'(paddle_pos), 200);
        check("init quad_error count", qerr_seen, 0);
        check("init prev", 32'(dut.r_prev), 3);

        // Re-reset at rest 00
        {rota, rotb} = 2'b00;
        RESET = 1'b1;
        repeat (2) @(posedge CLK); #1;
        RESET = 1'b0;
        model_pos = 200;
        repeat (HOLD + 5) @(posedge CLK); #1;
        check("rest prev", 32'(dut.r_prev), 0);

        foreach (vecs[v]) begin
            q0 = qerr_seen;
            for (int r = 0; r < vecs[v].reps; r++)
                drive_detent(vecs[v].seq, vecs[v].steps, vecs[v].dir);
            check($sformatf("vec%0d pos", v), 32'(paddle_pos), model_pos);
            check($sformatf("vec%0d quad_error", v), qerr_seen - q0, 0);
            check($sformatf("vec%0d pending", v), sb.size(), 0);
        end

        // Short glitch on rota must be rejected
        q0 = qerr_seen;
        rota = 1'b1;
        repeat (3) @(posedge CLK); #1;
        rota = 1'b0;
        repeat (HOLD) @(posedge CLK); #1;
        check("glitch stable_a", 32'(dut.u_deb_a.r_stable), 0);
        check("glitch prev", 32'(dut.r_prev), 0);
        check("glitch pos", 32'(paddle_pos), model_pos);
        check("glitch quad_error", qerr_seen - q0, 0);

        // Illegal jumps clear a partial detent
        q0 = qerr_seen;
        set_pins(2'b01, HOLD);
        set_pins(2'b11, HOLD);
        check("substep before illegal", 32'(dut.r_substep), 2);
        set_pins(2'b00, HOLD);
        check("illegal 11->00 quad_error", qerr_seen - q0, 1);
        check("illegal 11->00 substep", 32'(dut.r_substep), 0);
        set_pins(2'b11, HOLD);
        check("illegal 00->11 quad_error", qerr_seen - q0, 2);
        check("illegal 00->11 substep", 32'(dut.r_substep), 0);
        check("illegal pos", 32'(paddle_pos), model_pos);
        set_pins(2'b00, HOLD);
        check("illegal 11->00 again", qerr_seen - q0, 3);
        drive_detent(8'b01_11_10_00, 1'b1, 1'b1);
        check("detent after illegal pos", 32'(paddle_pos), model_pos);

        // Reset in the middle of a detent
        set_pins(2'b01, HOLD);
        set_pins(2'b11, HOLD);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_pos = 200;
        check("mid-detent reset pos", 32'(paddle_pos), 200);
        check("mid-detent reset substep", 32'(dut.r_substep), 0);
        set_pins(2'b11, HOLD);
        set_pins(2'b10, HOLD);
        check("post-reset quarter 1 pos", 32'(paddle_pos), 200);
        set_pins(2'b00, HOLD);
        check("post-reset quarter 2 pos", 32'(paddle_pos), 200);
        check("post-reset substep", 32'(dut.r_substep), 2);

        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
